// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
package cpu_ctrl_pkg;

  localparam int unsigned WAIT_W    = 8;
  localparam int unsigned RETIRED_W = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Legal R-type functs are 1000xx; the low two bits select the ALU op.
  localparam logic [3:0] FUNCT_ALU_HI = 4'b1000;

  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_ADDU  = 6'b100001;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_SUBU  = 6'b100011;
  localparam logic [5:0] ALU_LOAD  = 6'b001110;
  localparam logic [5:0] ALU_STORE = 6'b011110;
  localparam logic [5:0] ALU_BEQ   = 6'b000000;

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_decode.sv
// Combinational ALU operation decode and illegal-encoding detection.
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_control,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: illegal = (funct[5:2] != FUNCT_ALU_HI);
      OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: illegal = 1'b0;
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_control = 6'b000000;
    case (state)
      S_FETCH, S_DECODE: alu_control = ALU_ADDU;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: alu_control = {1'b1, 3'b000, funct[1:0]};
          OP_ADDI:  alu_control = ALU_ADD;
          OP_ADDIU: alu_control = ALU_ADDU;
          OP_LW:    alu_control = ALU_LOAD;
          OP_SW:    alu_control = ALU_STORE;
          default:  alu_control = 6'b000000;
        endcase
      end
      S_BRANCH: alu_control = ALU_BEQ;
      default:  alu_control = 6'b000000;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM with memory-wait timeout and retired counter.
// Optional macro ILLEGAL_TRAP_EN: illegal encodings trap and set sticky illegalOp.
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 isZero,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 pcWriteCond,
  output logic                 irWrite,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 iOrD,
  output logic                 regWrite,
  output logic                 regDst,
  output logic                 memToReg,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           pcSource,
  output logic [5:0]           aluControl,
  output logic [2:0]           state,
  output logic                 memFault,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegalOp,
`endif
  output logic [RETIRED_W-1:0] retired
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_inc;
  logic              wait_expired;
  logic              fault_set;
  logic              retire;
  logic              illegal;
  logic              is_lw, is_sw, is_rtype;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_set;
`endif

  alu_op_decode u_alu_op_decode (
    .state       (state_q),
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (aluControl),
    .illegal     (illegal)
  );

  assign is_lw        = (opcode == OP_LW);
  assign is_sw        = (opcode == OP_SW);
  assign is_rtype     = (opcode == OP_RTYPE);
  assign wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      memFault <= 1'b0;
      retired  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegalOp <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // Counter restarts on every state entry.
      if (state_d != state_q) wait_q <= '0;
      else if (wait_inc)      wait_q <= wait_q + WAIT_W'(1);
      if (fault_set) memFault <= 1'b1;
      if (retire)    retired  <= retired + RETIRED_W'(1);
`ifdef ILLEGAL_TRAP_EN
      if (illegal_set) illegalOp <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_inc    = 1'b0;
    fault_set   = 1'b0;
    retire      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iOrD        = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'd0;
    pcSource    = 2'd0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        irWrite = memReady;
        pcWrite = memReady;
        aluSrcB = 2'd1;
        // memReady wins over an expiring wait on the same cycle.
        if (memReady)          state_d = S_DECODE;
        else if (wait_expired) begin
          state_d   = S_TRAP;
          fault_set = 1'b1;
        end else               wait_inc = 1'b1;
      end
      S_DECODE: begin
        aluSrcB = 2'd3;
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d     = S_TRAP;
          illegal_set = 1'b1;
`else
          state_d     = S_FETCH;
`endif
        end
        else if (opcode == OP_BEQ) state_d = S_BRANCH;
        else if (opcode == OP_J)   state_d = S_JUMP;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = is_rtype ? 2'd0 : 2'd2;
        state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        iOrD     = 1'b1;
        memRead  = is_lw;
        memWrite = is_sw;
        if (memReady) begin
          if (is_lw) state_d = S_WB;
          else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          fault_set = 1'b1;
        end else wait_inc = 1'b1;
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = is_rtype;
        memToReg = is_lw;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        pcWriteCond = 1'b1;
        pcSource    = 2'd1;
        pcWrite     = isZero;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'd2;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed table, corner sequences, random trace model.
module tb_multi_cycle_ctrl;

  localparam int unsigned TMO = 4;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4, ST_B = 3'd5, ST_J = 3'd6, ST_T = 3'd7;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_J = 6'b000010, OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000, OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_LW = 6'b100011, OPC_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        isZero = 1'b0;
  logic        memReady = 1'b0;
  logic        pcWrite, pcWriteCond, irWrite, memRead, memWrite, iOrD;
  logic        regWrite, regDst, memToReg, aluSrcA;
  logic [1:0]  aluSrcB, pcSource;
  logic [5:0]  aluControl;
  logic [2:0]  state;
  logic        memFault;
  logic [31:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic        illegalOp;
`endif

  multi_cycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .isZero(isZero),
    .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSource(pcSource), .aluControl(aluControl),
    .state(state), .memFault(memFault),
`ifdef ILLEGAL_TRAP_EN
    .illegalOp(illegalOp),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, irw, mrd, mwr, iord, rw, rdst, m2r, asa;
    logic [1:0] asb, pcs;
    logic [5:0] alu;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       iz;
    int         df;
    int         dm;
    string      seq;
  } vec_t;

  ctl_t        got;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mret = '0;
  logic [2:0]  exp_st[$];
  vec_t        vecs[$];

  assign got = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, iOrD, regWrite,
                regDst, memToReg, aluSrcA, aluSrcB, pcSource, aluControl};

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, g, e);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OPC_R) return fn[5:2] == 4'b1000;
    return op inside {OPC_J, OPC_BEQ, OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW};
  endfunction

  // Expected strobes for a given state, straight from the per-state output rules.
  function automatic ctl_t exp_ctl(input logic [2:0] st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic mr, input logic iz);
    ctl_t c = '0;
    case (st)
      ST_F: begin c.mrd = 1; c.irw = mr; c.pcw = mr; c.asb = 2'd1; c.alu = 6'b100001; end
      ST_D: begin c.asb = 2'd3; c.alu = 6'b100001; end
      ST_E: begin
        c.asa = 1;
        c.asb = (op == OPC_R) ? 2'd0 : 2'd2;
        if (op == OPC_R)          c.alu = {4'b1000, fn[1:0]};
        else if (op == OPC_ADDI)  c.alu = 6'b100000;
        else if (op == OPC_ADDIU) c.alu = 6'b100001;
        else if (op == OPC_LW)    c.alu = 6'b001110;
        else if (op == OPC_SW)    c.alu = 6'b011110;
      end
      ST_M: begin c.iord = 1; c.mrd = (op == OPC_LW); c.mwr = (op == OPC_SW); end
      ST_W: begin c.rw = 1; c.rdst = (op == OPC_R); c.m2r = (op == OPC_LW); end
      ST_B: begin c.asa = 1; c.pcwc = 1; c.pcs = 2'd1; c.pcw = iz; end
      ST_J: begin c.pcw = 1; c.pcs = 2'd2; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Reference trace: list of states one instruction visits, given ready delays.
  task automatic model_trace(input logic [5:0] op, input logic [5:0] fn, input int df, input int dm);
    exp_st.delete();
    for (int i = 0; i < 300; i++) begin
      exp_st.push_back(ST_F);
      if (i == df) break;
      if (i + 1 == int'(TMO)) begin exp_st.push_back(ST_T); return; end
    end
    exp_st.push_back(ST_D);
    if (!is_legal(op, fn)) begin
`ifdef ILLEGAL_TRAP_EN
      exp_st.push_back(ST_T);
`endif
      return;
    end
    if (op == OPC_BEQ) begin exp_st.push_back(ST_B); return; end
    if (op == OPC_J)   begin exp_st.push_back(ST_J); return; end
    exp_st.push_back(ST_E);
    if (op == OPC_LW || op == OPC_SW) begin
      for (int i = 0; i < 300; i++) begin
        exp_st.push_back(ST_M);
        if (i == dm) break;
        if (i + 1 == int'(TMO)) begin exp_st.push_back(ST_T); return; end
      end
      if (op == OPC_LW) exp_st.push_back(ST_W);
    end else begin
      exp_st.push_back(ST_W);
    end
  endtask

  // Entered at a falling edge; leaves at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    memReady = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    memReady = 1'b0;
    mret = '0;
    #1;
    chk("rst_state", 32'(state), 32'(ST_F));
    chk("rst_memRead", 32'(memRead), 32'd1);
    chk("rst_retired", retired, 32'd0);
    chk("rst_memFault", 32'(memFault), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("rst_illegalOp", 32'(illegalOp), 32'd0);
`endif
  endtask

  // Drive one instruction along exp_st, checking state and strobes every cycle.
  task automatic run_seq(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic iz, input int df, input int dm);
    int fi = 0, mi = 0;
    logic mr;
    logic [2:0] st, last, prev;
    opcode = op; funct = fn; isZero = iz;
    for (int k = 0; k < exp_st.size(); k++) begin
      st = exp_st[k];
      if (st == ST_F)      begin mr = (fi == df); fi++; end
      else if (st == ST_M) begin mr = (mi == dm); mi++; end
      else                 mr = 1'($urandom);
      memReady = mr;
      #1;
      if (k == 0) begin
        chk({nm, "_retired"}, retired, mret);
        chk({nm, "_memFault0"}, 32'(memFault), 32'd0);
      end
      chk($sformatf("%s_state_c%0d", nm, k), 32'(state), 32'(st));
      chk($sformatf("%s_ctl_c%0d", nm, k), 32'(got), 32'(exp_ctl(st, op, fn, mr, iz)));
      @(negedge clk);
    end
    memReady = 1'b0;
    last = exp_st[exp_st.size() - 1];
    if (last == ST_T) begin
      prev = exp_st[exp_st.size() - 2];
      #1;
      chk({nm, "_trap_hold"}, 32'(state), 32'(ST_T));
      chk({nm, "_trap_ctl"}, 32'(got), 32'd0);
      chk({nm, "_memFault"}, 32'(memFault), 32'((prev == ST_F) || (prev == ST_M)));
`ifdef ILLEGAL_TRAP_EN
      chk({nm, "_illegalOp"}, 32'(illegalOp), 32'(prev == ST_D));
`endif
    end else if (last inside {ST_W, ST_B, ST_J} || (last == ST_M && op == OPC_SW)) begin
      mret = mret + 32'd1;
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic iz,
                         input int df, input int dm, input string seq);
    vec_t v;
    v.op = op; v.fn = fn; v.iz = iz; v.df = df; v.dm = dm; v.seq = seq;
    vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] op, fn;
    int cls;

    add_vec(OPC_R,     6'b100010, 1'b0, 0, 0, "0124");
    add_vec(OPC_LW,    6'b000000, 1'b0, 1, 3, "001233334");
    add_vec(OPC_SW,    6'b000000, 1'b0, 0, 0, "0123");
    add_vec(OPC_BEQ,   6'b000000, 1'b1, 0, 0, "015");
    add_vec(OPC_BEQ,   6'b000000, 1'b0, 0, 0, "015");
    add_vec(OPC_J,     6'b000000, 1'b0, 0, 0, "016");
    add_vec(OPC_ADDI,  6'b000000, 1'b0, 2, 0, "000124");
    add_vec(OPC_ADDIU, 6'b000000, 1'b0, 0, 0, "0124");
    add_vec(OPC_R,     6'b100000, 1'b0, 3, 0, "0000124");
    add_vec(OPC_SW,    6'b000000, 1'b0, 0, 3, "0123333");
`ifdef ILLEGAL_TRAP_EN
    add_vec(6'b111111, 6'b000000, 1'b0, 0, 0, "017");
    add_vec(OPC_R,     6'b101010, 1'b0, 0, 0, "017");
`else
    add_vec(6'b111111, 6'b000000, 1'b0, 0, 0, "01");
    add_vec(OPC_R,     6'b101010, 1'b0, 0, 0, "01");
`endif
    add_vec(OPC_LW,    6'b000000, 1'b0, 0, 4, "01233337");
    add_vec(OPC_ADDI,  6'b000000, 1'b0, 9, 0, "00007");

    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      exp_st.delete();
      for (int c = 0; c < vecs[i].seq.len(); c++)
        exp_st.push_back(3'(vecs[i].seq[c] - 8'h30));
      run_seq($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].iz, vecs[i].df, vecs[i].dm);
      if (exp_st[exp_st.size() - 1] == ST_T) do_reset();
    end

    // Reset during a memory access with memReady pending must win.
    opcode = OPC_LW; memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("prio_in_mem", 32'(state), 32'(ST_M));
    reset = 1'b1; memReady = 1'b1;
    @(negedge clk);
    reset = 1'b0; memReady = 1'b0;
    mret = '0;
    #1;
    chk("prio_state", 32'(state), 32'(ST_F));
    chk("prio_retired", retired, 32'd0);

    for (int r = 0; r < 80; r++) begin
      cls = int'($urandom_range(0, 8));
      fn  = 6'($urandom);
      case (cls)
        0: begin op = OPC_R; fn = {4'b1000, 2'($urandom)}; end
        1: op = OPC_J;
        2: op = OPC_BEQ;
        3: op = OPC_ADDI;
        4: op = OPC_ADDIU;
        5: op = OPC_LW;
        6: op = OPC_SW;
        7: op = {2'b11, 4'($urandom)};
        default: begin op = OPC_R; fn = {2'b01, 4'($urandom)}; end
      endcase
      model_trace(op, fn, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      begin
        int df, dm, fc, mc;
        fc = 0; mc = 0;
        foreach (exp_st[j]) begin
          if (exp_st[j] == ST_F) fc++;
          if (exp_st[j] == ST_M) mc++;
        end
        df = (exp_st[exp_st.size() - 1] == ST_T && exp_st[exp_st.size() - 2] == ST_F) ? 99 : fc - 1;
        dm = (exp_st[exp_st.size() - 1] == ST_T && exp_st[exp_st.size() - 2] == ST_M) ? 99 : mc - 1;
        run_seq($sformatf("rnd%0d", r), op, fn, 1'($urandom), df, dm);
      end
      if (exp_st[exp_st.size() - 1] == ST_T) do_reset();
    end

    #1;
    chk("final_retired", retired, mret);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
